// File: rtl/pipe_ctrl.sv
// Hazard/redirect controller for the 5-stage core: stall priority, branch/mret
// redirects and trap/interrupt entry sequencing. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_if_i,
  input  logic            stallreq_id_i,
  input  logic            stallreq_ex_i,
  input  logic            stallreq_mem_i,
  input  logic            branch_req_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] mem_pc_i,
  input  logic            mem_valid_i,
  input  logic            irq_i,
  input  logic            irq_en_i,
  input  logic [XLEN-1:0] irq_cause_i,
  input  logic            mret_req_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic [5:0]      stall_o,
  output logic [4:0]      flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            trap_commit_o,
  output logic [XLEN-1:0] trap_epc_o,
  output logic [XLEN-1:0] trap_cause_o,
  output logic            mret_commit_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [XLEN-1:0] perf_stall_cnt_o,
  output logic [XLEN-1:0] perf_flush_cnt_o
`endif
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_TRAP_CSR  = 2'd1;
  localparam logic [1:0] ST_TRAP_JUMP = 2'd2;

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic            idle_s;
  logic            irq_take_s;
  logic            trap_take_s;
  logic            mret_take_s;
  logic            branch_take_s;
  logic [5:0]      stall_s;
  logic [4:0]      flush_s;
  logic            redirect_valid_s;
  logic [XLEN-1:0] redirect_pc_s;
  logic            trap_commit_s;
  logic            mret_commit_s;
  logic [XLEN-1:0] trap_epc_r;
  logic [XLEN-1:0] trap_cause_r;

  // Requests are only honoured in IDLE and never while reset is asserted.
  assign idle_s        = (state_r == ST_IDLE) && !rst;
  assign irq_take_s    = irq_i && irq_en_i && mem_valid_i;
  assign trap_take_s   = idle_s && !stallreq_mem_i && (trap_req_i || irq_take_s);
  assign mret_take_s   = idle_s && !stallreq_mem_i && mret_req_i && !trap_take_s;
  assign branch_take_s = idle_s && branch_req_i && !stallreq_mem_i && !stallreq_ex_i
                         && !trap_take_s && !mret_take_s;

  // Output decode and next-state selection.
  always_comb begin
    state_nxt_s      = state_r;
    stall_s          = 6'b000000;
    flush_s          = 5'b00000;
    redirect_valid_s = 1'b0;
    redirect_pc_s    = {XLEN{1'b0}};
    trap_commit_s    = 1'b0;
    mret_commit_s    = 1'b0;
    if (rst) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (trap_take_s) begin
            flush_s     = 5'b01110;
            state_nxt_s = ST_TRAP_CSR;
          end else if (mret_take_s) begin
            flush_s          = 5'b01110;
            redirect_valid_s = 1'b1;
            redirect_pc_s    = mepc_i;
            mret_commit_s    = 1'b1;
          end else if (branch_take_s) begin
            // id/if stall requests belong to the squashed instructions
            flush_s          = 5'b00110;
            redirect_valid_s = 1'b1;
            redirect_pc_s    = branch_pc_i;
          end else begin
            if (stallreq_mem_i) begin
              stall_s = 6'b011111;
            end else if (stallreq_ex_i) begin
              stall_s = 6'b001111;
            end else if (stallreq_id_i) begin
              stall_s = 6'b000111;
            end else if (stallreq_if_i) begin
              stall_s = 6'b000011;
            end else begin
              stall_s = 6'b000000;
            end
          end
        end
        ST_TRAP_CSR: begin
          trap_commit_s = 1'b1;
          stall_s       = 6'b000011;
          flush_s       = 5'b00010;
          state_nxt_s   = ST_TRAP_JUMP;
        end
        ST_TRAP_JUMP: begin
          redirect_valid_s = 1'b1;
          redirect_pc_s    = mtvec_i;
          flush_s          = 5'b00010;
          state_nxt_s      = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // EPC/cause captured at trap accept, held for the CSR commit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_epc_r   <= {XLEN{1'b0}};
      trap_cause_r <= {XLEN{1'b0}};
    end else if (trap_take_s) begin
      trap_epc_r   <= mem_pc_i;
      trap_cause_r <= trap_req_i ? trap_cause_i : irq_cause_i;
    end else begin
      trap_epc_r   <= trap_epc_r;
      trap_cause_r <= trap_cause_r;
    end
  end

  assign stall_o          = stall_s;
  assign flush_o          = flush_s;
  assign redirect_valid_o = redirect_valid_s;
  assign redirect_pc_o    = redirect_pc_s;
  assign trap_commit_o    = trap_commit_s;
  assign mret_commit_o    = mret_commit_s;
  assign trap_epc_o       = trap_epc_r;
  assign trap_cause_o     = trap_cause_r;

`ifdef PIPE_CTRL_PERF_EN
  logic [XLEN-1:0] perf_stall_cnt_r;
  logic [XLEN-1:0] perf_flush_cnt_r;

  // Cycle counters for stalled and flushing cycles; wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_r <= {XLEN{1'b0}};
      perf_flush_cnt_r <= {XLEN{1'b0}};
    end else begin
      if (stall_s != 6'b000000) begin
        perf_stall_cnt_r <= perf_stall_cnt_r + {{(XLEN-1){1'b0}}, 1'b1};
      end
      if (flush_s != 5'b00000) begin
        perf_flush_cnt_r <= perf_flush_cnt_r + {{(XLEN-1){1'b0}}, 1'b1};
      end
    end
  end

  assign perf_stall_cnt_o = perf_stall_cnt_r;
  assign perf_flush_cnt_o = perf_flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random stimulus
// against a rule-level reference model.
module tb_pipe_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic            branch_req_i;
  logic [XLEN-1:0] branch_pc_i;
  logic            trap_req_i;
  logic [XLEN-1:0] trap_cause_i, mem_pc_i;
  logic            mem_valid_i, irq_i, irq_en_i;
  logic [XLEN-1:0] irq_cause_i;
  logic            mret_req_i;
  logic [XLEN-1:0] mtvec_i, mepc_i;
  logic [5:0]      stall_o;
  logic [4:0]      flush_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            trap_commit_o;
  logic [XLEN-1:0] trap_epc_o, trap_cause_o;
  logic            mret_commit_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [XLEN-1:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

  pipe_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
    .branch_req_i(branch_req_i), .branch_pc_i(branch_pc_i),
    .trap_req_i(trap_req_i), .trap_cause_i(trap_cause_i),
    .mem_pc_i(mem_pc_i), .mem_valid_i(mem_valid_i),
    .irq_i(irq_i), .irq_en_i(irq_en_i), .irq_cause_i(irq_cause_i),
    .mret_req_i(mret_req_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .stall_o(stall_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .trap_commit_o(trap_commit_o), .trap_epc_o(trap_epc_o),
    .trap_cause_o(trap_cause_o), .mret_commit_o(mret_commit_o)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: trap_left counts the cycles still owed to trap entry
  // (2 = CSR write cycle pending, 1 = vector jump pending, 0 = free).
  int              trap_left = 0;
  logic [XLEN-1:0] epc_m = '0, cause_m = '0;
  int              n_trap_left;
  logic [XLEN-1:0] n_epc, n_cause;
  longint unsigned stall_cycles = 0, flush_cycles = 0;
  logic            e_stalled, e_flushed;

  task automatic settle();
    logic [5:0]      e_stall;
    logic [4:0]      e_flush;
    logic            e_rv, e_commit, e_mret;
    logic [XLEN-1:0] e_rpc;
    int              lvl;
    #1;
    e_stall = '0; e_flush = '0; e_rv = 0; e_rpc = '0; e_commit = 0; e_mret = 0;
    n_trap_left = trap_left; n_epc = epc_m; n_cause = cause_m;
    if (rst) begin
      n_trap_left = 0; n_epc = '0; n_cause = '0;
    end else if (trap_left == 2) begin
      e_commit = 1; e_stall = 6'b000011; e_flush = 5'b00010; n_trap_left = 1;
    end else if (trap_left == 1) begin
      e_rv = 1; e_rpc = mtvec_i; e_flush = 5'b00010; n_trap_left = 0;
    end else if (!stallreq_mem_i && (trap_req_i || (irq_i && irq_en_i && mem_valid_i))) begin
      e_flush = 5'b01110; n_trap_left = 2; n_epc = mem_pc_i;
      n_cause = trap_req_i ? trap_cause_i : irq_cause_i;
    end else if (!stallreq_mem_i && mret_req_i) begin
      e_rv = 1; e_rpc = mepc_i; e_flush = 5'b01110; e_mret = 1;
    end else begin
      // A stalling stage at depth d holds PC and every stage up to d.
      lvl = stallreq_mem_i ? 5 : stallreq_ex_i ? 4 : 0;
      if (lvl == 0 && branch_req_i) begin
        e_rv = 1; e_rpc = branch_pc_i; e_flush = 5'b00110;
      end else if (lvl == 0) begin
        lvl = stallreq_id_i ? 3 : stallreq_if_i ? 2 : 0;
      end
      e_stall = 6'((1 << lvl) - 1);
    end
    check("stall", stall_o, e_stall);
    check("flush", flush_o, e_flush);
    check("redirect_valid", redirect_valid_o, e_rv);
    check("redirect_pc", redirect_pc_o, e_rpc);
    check("trap_commit", trap_commit_o, e_commit);
    check("mret_commit", mret_commit_o, e_mret);
    check("trap_epc", trap_epc_o, epc_m);
    check("trap_cause", trap_cause_o, cause_m);
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall", perf_stall_cnt_o, stall_cycles & 64'hFFFF_FFFF);
    check("perf_flush", perf_flush_cnt_o, flush_cycles & 64'hFFFF_FFFF);
`endif
    e_stalled = (e_stall != 0);
    e_flushed = (e_flush != 0);
  endtask

  task automatic advance();
    trap_left = n_trap_left; epc_m = n_epc; cause_m = n_cause;
    if (rst) begin
      stall_cycles = 0; flush_cycles = 0;
    end else begin
      if (e_stalled) stall_cycles++;
      if (e_flushed) flush_cycles++;
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic clear_reqs();
    stallreq_if_i = 0; stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
    branch_req_i = 0; trap_req_i = 0; mem_valid_i = 0; irq_i = 0; irq_en_i = 0;
    mret_req_i = 0;
  endtask

  longint unsigned flush_before;

  initial begin
    rst = 1; branch_pc_i = 32'h80; trap_cause_i = 32'h2; mem_pc_i = 32'h100;
    irq_cause_i = 32'h8000_000B; mtvec_i = 32'h200; mepc_i = 32'h104;
    stallreq_if_i = 1; stallreq_id_i = 1; stallreq_ex_i = 1; stallreq_mem_i = 1;
    branch_req_i = 1; trap_req_i = 1; mem_valid_i = 1; irq_i = 1; irq_en_i = 1;
    mret_req_i = 1;
    @(negedge clk);
    // Reset with every request high: outputs must be silent.
    for (int i = 0; i < 2; i++) begin
      settle();
      check("rst_stall", stall_o, 6'b000000);
      check("rst_redirect", redirect_valid_o, 1'b0);
      advance();
    end
    rst = 0; clear_reqs();
    step();

    // Stall priority.
    stallreq_id_i = 1; stallreq_ex_i = 1;
    settle(); check("prio_ex", stall_o, 6'b001111); advance();
    stallreq_ex_i = 0;
    settle(); check("prio_id", stall_o, 6'b000111); advance();

    // Branch over load-use.
    branch_req_i = 1;
    settle();
    check("br_stall", stall_o, 6'b000000);
    check("br_flush", flush_o, 5'b00110);
    check("br_pc", redirect_pc_o, 32'h80);
    advance();
    clear_reqs();

    // Trap held off by data-bus wait, then accepted.
    trap_req_i = 1; stallreq_mem_i = 1;
    for (int i = 0; i < 3; i++) begin
      settle(); check("trapwait_stall", stall_o, 6'b011111); check("trapwait_flush", flush_o, 5'b00000); advance();
    end
    stallreq_mem_i = 0;
    settle(); check("trap_accept", flush_o, 5'b01110); advance();
    trap_req_i = 0;
    settle(); check("trap_commit1", trap_commit_o, 1'b1); check("trap_epc1", trap_epc_o, 32'h100); advance();
    settle(); check("trap_vec", redirect_pc_o, 32'h200); advance();

    // Interrupt beats branch.
    irq_i = 1; irq_en_i = 1; mem_valid_i = 1; branch_req_i = 1;
    settle(); check("irq_nobranch", redirect_valid_o, 1'b0); advance();
    clear_reqs();
    settle(); check("irq_cause", trap_cause_o, 32'h8000_000B); advance();
    settle(); check("irq_vec", redirect_pc_o, 32'h200); advance();

    // mret.
    flush_before = flush_cycles;
    mret_req_i = 1;
    settle();
    check("mret_pc", redirect_pc_o, 32'h104);
    check("mret_commit", mret_commit_o, 1'b1);
    check("mret_flush", flush_o, 5'b01110);
    advance();
    mret_req_i = 0;
    settle();
    check("mret_flushcnt", flush_cycles - flush_before, 64'd1);
    advance();

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      rst            = ($urandom_range(0, 99) == 0);
      stallreq_if_i  = ($urandom_range(0, 3) == 0);
      stallreq_id_i  = ($urandom_range(0, 3) == 0);
      stallreq_ex_i  = ($urandom_range(0, 4) == 0);
      stallreq_mem_i = ($urandom_range(0, 3) == 0);
      branch_req_i   = ($urandom_range(0, 2) == 0);
      trap_req_i     = ($urandom_range(0, 9) == 0);
      mret_req_i     = ($urandom_range(0, 9) == 0);
      irq_i          = ($urandom_range(0, 5) == 0);
      irq_en_i       = $urandom_range(0, 1) == 1;
      mem_valid_i    = $urandom_range(0, 3) != 0;
      branch_pc_i    = $urandom; trap_cause_i = $urandom_range(0, 15);
      mem_pc_i       = $urandom; irq_cause_i  = 32'h8000_0000 | $urandom_range(0, 15);
      mtvec_i        = $urandom; mepc_i       = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard/redirect controller for the 5-stage core (PC, IF, ID, EX, MEM, WB).
- Drives the stall_o[5:0] and flush_o[4:0] vectors consumed by the PC register and the if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Prioritises stall requests, issues branch/mret redirects, and sequences trap/interrupt entry through a 3-state FSM with a one-cycle CSR commit.

Parameters:
- XLEN, 32, width of PC/address/cause buses.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- stallreq_if_i  in  1  fetch bus wait
- stallreq_id_i  in  1  load-use hazard
- stallreq_ex_i  in  1  multi-cycle EX op (div) busy
- stallreq_mem_i  in  1  data bus wait
- branch_req_i  in  1  EX resolved taken branch/jump
- branch_pc_i  in  XLEN  branch target
- trap_req_i  in  1  MEM synchronous exception
- trap_cause_i  in  XLEN  exception cause
- mem_pc_i  in  XLEN  PC of instruction in MEM
- mem_valid_i  in  1  MEM holds a real (non-bubble) instruction
- irq_i  in  1  external interrupt, level
- irq_en_i  in  1  mstatus.MIE & mie
- irq_cause_i  in  XLEN  interrupt cause (MSB set)
- mret_req_i  in  1  MEM mret
- mtvec_i  in  XLEN  trap vector
- mepc_i  in  XLEN  return address
- stall_o  out  6  [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
- flush_o  out  5  [1]if_id [2]id_ex [3]ex_mem [4]mem_wb; [0] fetch kill
- redirect_valid_o  out  1  load redirect_pc_o into PC
- redirect_pc_o  out  XLEN  new PC
- trap_commit_o  out  1  one-cycle CSR write strobe (mepc/mcause)
- trap_epc_o  out  XLEN  latched EPC
- trap_cause_o  out  XLEN  latched cause
- mret_commit_o  out  1  one-cycle mstatus restore strobe

Behaviour:
- Reset: every output 0; FSM = IDLE; trap_epc_o/trap_cause_o = 0. Reset mid-trap returns to IDLE with no commit.
- Stall encoding (combinational, IDLE only), highest stage wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 0
- Branch: accepted when branch_req_i & !stall_o[3] & no trap/mret/irq taken this cycle.
  - Same cycle: redirect_valid_o=1, redirect_pc_o=branch_pc_i, flush_o=5'b00110.
  - stallreq_id_i and stallreq_if_i are masked to 0 (they belong to squashed instructions).
- mret: accepted in IDLE when mret_req_i & !stallreq_mem_i.
  - Same cycle: redirect to mepc_i, flush_o=5'b01110, mret_commit_o=1.
- Trap accept (IDLE): take = !stallreq_mem_i & (trap_req_i | (irq_i & irq_en_i & mem_valid_i)).
  - Synchronous trap outranks irq; both outrank mret, which outranks branch.
  - Accept cycle: flush_o=5'b01110, stall_o=0.
  - Latch trap_epc_o=mem_pc_i. Latch trap_cause_o = trap_cause_i, or irq_cause_i if interrupt.
  - Next state TRAP_CSR.
- Trap while stallreq_mem_i=1: not taken; normal mem stall; retried every cycle.
- TRAP_CSR (1 cycle): trap_commit_o=1, stall_o=6'b000011, flush_o=5'b00010; → TRAP_JUMP.
- TRAP_JUMP (1 cycle): redirect_valid_o=1, redirect_pc_o=mtvec_i, flush_o=5'b00010, stall_o=0; → IDLE.
- Outside IDLE: all request inputs ignored; irq_i not re-sampled.
- Trap total latency: accept → redirect = 2 cycles. Branch and mret redirect latency = 0 cycles.
- redirect_pc_o = 0 whenever redirect_valid_o=0.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cnt_o and perf_flush_cnt_o (XLEN each).
  - perf_stall_cnt_o increments each cycle stall_o!=0; perf_flush_cnt_o increments each cycle flush_o!=0.
  - Both wrap modulo 2^XLEN; cleared by rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: rst=1 for 2 cycles with all requests high → all outputs 0; after release, FSM=IDLE.
- Stall priority: stallreq_id_i=1 & stallreq_ex_i=1 → stall_o=6'b001111; drop ex → 6'b000111.
- Branch over load-use: stallreq_id_i=1, branch_req_i=1, branch_pc_i=0x80 → same cycle stall_o=0, flush_o=5'b00110, redirect_pc_o=0x80.
- Trap during mem wait: trap_req_i=1, mem_pc_i=0x100, stallreq_mem_i=1 for 3 cycles → stall_o=6'b011111, no flush. Then:
  - accept cycle: flush_o=5'b01110
  - +1: trap_commit_o=1, trap_epc_o=0x100
  - +2: redirect to mtvec_i=0x200
- Irq vs branch: irq_i=irq_en_i=mem_valid_i=1 with branch_req_i=1 → branch dropped, trap_cause_o=irq_cause_i=0x8000000B, redirect to mtvec_i two cycles later.
- mret: mret_req_i=1, mepc_i=0x104 → redirect_pc_o=0x104, mret_commit_o=1, flush_o=5'b01110. With PIPE_CTRL_PERF_EN defined, perf_flush_cnt_o increments by 1.
